// File: rtl/leb128_fetch.sv
// leb128_fetch: immediate-operand fetch stage between the instruction ROM and
// execute. On a request it reads one ROM window at a byte address, then
// decodes one WebAssembly LEB128 immediate (signed/unsigned, 32/64-bit) at one
// byte per cycle. The result goes out over a valid/ready handshake.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_addr              byte address of the first LEB128 byte
//   req_signed, req_wide  signed LEB128 / 64-bit operand
//   mem_addr, mem_extra   ROM address and window-size field (always full window)
//   mem_data, mem_error   ROM window (first byte in the MSBs) and bounds error
//   rsp_valid/rsp_ready   response handshake
//   rsp_value/len/error   value (extended to 64), bytes consumed, error code
module leb128_fetch #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4,
  localparam int W = (2 ** MEM_EXTRA) * 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MEM_DEPTH:0]   req_addr,
  input  logic                 req_signed,
  input  logic                 req_wide,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [MEM_EXTRA-1:0] mem_extra,
  input  logic [W-1:0]         mem_data,
  input  logic                 mem_error,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_value,
  output logic [3:0]           rsp_len,
  output logic [1:0]           rsp_error
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DECODE, S_DONE} state_t;

  localparam logic [1:0] E_OK   = 2'd0;
  localparam logic [1:0] E_MEM  = 2'd1;
  localparam logic [1:0] E_UNT  = 2'd2;
  localparam logic [1:0] E_OVF  = 2'd3;

  state_t             state_q, state_d;
  logic [MEM_DEPTH:0] addr_q, addr_d;
  logic               sgn_q, sgn_d, wide_q, wide_d;
  logic [W-1:0]       win_q, win_d;
  logic               merr_q, merr_d;
  logic [3:0]         k_q, k_d;
  logic [63:0]        acc_q, acc_d;
  logic [63:0]        val_q, val_d;
  logic [3:0]         len_q, len_d;
  logic [1:0]         err_q, err_d;

  // Decode datapath for the byte currently at the top of the window.
  logic [7:0]  cur;
  logic [6:0]  pay;
  logic [5:0]  k7;      // 7*k mod 64; k <= 9 so it never wraps
  logic [6:0]  l7;      // 7*(k+1), up to 70
  logic [3:0]  len_nx, limit;
  logic        at_lim, ovf;
  logic [63:0] acc_nx, ext, fin;

  always_comb begin
    cur    = win_q[W-1 -: 8];
    pay    = cur[6:0];
    k7     = {k_q[2:0], 3'b000} - {2'b00, k_q};
    len_nx = k_q + 4'd1;
    l7     = {len_nx, 3'b000} - {3'b000, len_nx};
    limit  = wide_q ? 4'd10 : 4'd5;
    at_lim = (len_nx == limit);
    acc_nx = acc_q | ({57'd0, pay} << k7);

    // Bits of the final byte that would land beyond the operand width.
    unique case ({sgn_q, wide_q})
      2'b00:   ovf = (pay[6:4] != 3'd0);
      2'b10:   ovf = (pay[6:3] != 4'h0) && (pay[6:3] != 4'hF);
      2'b01:   ovf = (pay[6:1] != 6'd0);
      default: ovf = (pay != 7'h00) && (pay != 7'h7F);
    endcase

    // Signed fill only while the payload bits have not already reached bit 63.
    ext = acc_nx;
    if (sgn_q && pay[6] && !l7[6])
      ext = acc_nx | ({64{1'b1}} << l7[5:0]);
    fin = wide_q ? ext
                 : (sgn_q ? {{32{ext[31]}}, ext[31:0]} : {32'd0, ext[31:0]});
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sgn_d   = sgn_q;
    wide_d  = wide_q;
    win_d   = win_q;
    merr_d  = merr_q;
    k_d     = k_q;
    acc_d   = acc_q;
    val_d   = val_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          sgn_d   = req_signed;
          wide_d  = req_wide;
          state_d = S_READ;
        end
      end
      S_READ: begin
        win_d   = mem_data;
        merr_d  = mem_error;
        k_d     = 4'd0;
        acc_d   = 64'd0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (merr_q) begin
          // A bounds error from the ROM is final; no bytes are examined.
          val_d   = 64'd0;
          len_d   = 4'd0;
          err_d   = E_MEM;
          state_d = S_DONE;
        end else if (!cur[7]) begin
          len_d   = len_nx;
          state_d = S_DONE;
          if (at_lim && ovf) begin
            val_d = 64'd0;
            err_d = E_OVF;
          end else begin
            val_d = fin;
            err_d = E_OK;
          end
        end else if (at_lim) begin
          val_d   = 64'd0;
          len_d   = len_nx;
          err_d   = E_UNT;
          state_d = S_DONE;
        end else begin
          acc_d = acc_nx;
          k_d   = len_nx;
          win_d = win_q << 8;
        end
      end
      default: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sgn_q   <= 1'b0;
      wide_q  <= 1'b0;
      win_q   <= '0;
      merr_q  <= 1'b0;
      k_q     <= 4'd0;
      acc_q   <= 64'd0;
      val_q   <= 64'd0;
      len_q   <= 4'd0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sgn_q   <= sgn_d;
      wide_q  <= wide_d;
      win_q   <= win_d;
      merr_q  <= merr_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign mem_addr  = addr_q;
  assign mem_extra = '1;
  assign rsp_value = val_q;
  assign rsp_len   = len_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_leb128_fetch.sv
// Bench for leb128_fetch: directed vectors plus randomized LEB128 encodings
// checked against an arithmetic reference model.
module tb_leb128_fetch;
  localparam int MD = 4;
  localparam int ME = 4;
  localparam int W  = 128;
  localparam int AW = MD + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_signed, req_wide;
  logic [AW-1:0] req_addr, mem_addr;
  logic [ME-1:0] mem_extra;
  logic [W-1:0]  mem_data;
  logic          mem_error;
  logic          rsp_valid, rsp_ready;
  logic [63:0]   rsp_value;
  logic [3:0]    rsp_len;
  logic [1:0]    rsp_error;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] rom [64];
  int         ub = 64;

  leb128_fetch #(.MEM_DEPTH(MD), .MEM_EXTRA(ME)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_signed(req_signed), .req_wide(req_wide),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_data(mem_data), .mem_error(mem_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_value(rsp_value), .rsp_len(rsp_len), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  // ROM: window bytes from mem_addr, first byte in the MSBs; error when the
  // window runs past the upper bound.
  always_comb begin
    mem_data = '0;
    for (int i = 0; i < 16; i++)
      mem_data[W-1-8*i -: 8] = rom[int'(mem_addr) + i];
    mem_error = (int'(mem_addr) + 16 > ub);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bytes right-aligned in b, first byte most significant.
  task automatic place(input int a, input int n, input logic [79:0] b);
    for (int i = 0; i < n; i++) rom[a+i] = b[8*(n-1-i) +: 8];
  endtask

  // Reference model: LEB128 as an arbitrary-precision number, range-checked.
  task automatic model(input int a, input bit s, input bit w,
                       output logic [63:0] v, output logic [3:0] l,
                       output logic [1:0] e, output int lat);
    logic signed [127:0] acc, val, lo, hi;
    int lim, n;
    bit term;
    acc = 0; term = 0; n = 0; lim = w ? 10 : 5;
    if (a + 16 > ub) begin
      v = 0; l = 0; e = 1; lat = 2;
      return;
    end
    for (int i = 0; i < lim && !term; i++) begin
      acc  = acc + (128'(rom[a+i][6:0]) << (7*i));
      n    = i + 1;
      term = !rom[a+i][7];
    end
    lat = n + 1;
    l   = 4'(n);
    if (!term) begin
      v = 0; e = 2;
      return;
    end
    val = acc;
    if (s && rom[a+n-1][6]) val = acc - (128'sd1 <<< (7*n));
    hi = s ? (128'sd1 <<< (w ? 63 : 31)) : (128'sd1 <<< (w ? 64 : 32));
    lo = s ? -hi : 128'sd0;
    if (val < lo || val >= hi) begin
      v = 0; e = 3;
    end else begin
      v = val[63:0]; e = 0;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge in DONE.
  task automatic issue(input int a, input bit s, input bit w,
                       output logic [63:0] v, output logic [3:0] l,
                       output logic [1:0] e, output int lat);
    int cyc;
    req_addr = AW'(a); req_signed = s; req_wide = w; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    lat = rsp_valid ? cyc - 1 : -1;
    v = rsp_value; l = rsp_len; e = rsp_error;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".rsp_valid_after_hs"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".req_ready_after_hs"}, 64'(req_ready), 64'd1);
  endtask

  task automatic run_exp(input string tag, input int a, input bit s, input bit w,
                         input logic [63:0] ev, input logic [3:0] el,
                         input logic [1:0] ee, input int elat);
    logic [63:0] v; logic [3:0] l; logic [1:0] e; int lat;
    issue(a, s, w, v, l, e, lat);
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".value"}, v, ev);
    chk({tag, ".len"}, 64'(l), 64'(el));
    chk({tag, ".error"}, 64'(e), 64'(ee));
    handshake(tag);
  endtask

  initial begin
    logic [63:0] ev, hv; logic [3:0] el; logic [1:0] ee; int elat, lat;
    logic [63:0] v; logic [3:0] l; logic [1:0] e;

    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_signed = 1'b0;
    req_wide = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("reset.req_ready", 64'(req_ready), 64'd1);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset.rsp_value", rsp_value, 64'd0);
    chk("reset.rsp_len", 64'(rsp_len), 64'd0);
    chk("reset.rsp_error", 64'(rsp_error), 64'd0);
    chk("reset.mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    place(0, 3, 80'hE58E26);
    run_exp("u32_3b", 0, 0, 0, 64'h0000000000098765, 3, 0, 4);
    place(5, 3, 80'hC0BB78);
    run_exp("s32_3b", 5, 1, 0, 64'hFFFFFFFFFFFE1DC0, 3, 0, 4);
    place(9, 1, 80'h7F);
    run_exp("s64_7f", 9, 1, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0, 2);
    run_exp("u64_7f", 9, 0, 1, 64'h000000000000007F, 1, 0, 2);
    place(3, 5, 80'hFFFFFFFF0F);
    run_exp("u32_max", 3, 0, 0, 64'h00000000FFFFFFFF, 5, 0, 6);
    place(3, 5, 80'hFFFFFFFF1F);
    run_exp("u32_ovf", 3, 0, 0, 64'd0, 5, 3, 6);
    place(12, 5, 80'h8080808080);
    run_exp("u32_unterm", 12, 0, 0, 64'd0, 5, 2, 6);
    place(1, 5, 80'h8080808078);
    run_exp("s32_min", 1, 1, 0, 64'hFFFFFFFF80000000, 5, 0, 6);
    place(1, 5, 80'h808080800F);
    run_exp("s32_ovf", 1, 1, 0, 64'd0, 5, 3, 6);
    place(4, 10, 80'hFFFFFFFFFFFFFFFFFF01);
    run_exp("u64_max", 4, 0, 1, 64'hFFFFFFFFFFFFFFFF, 10, 0, 11);
    place(4, 10, 80'hFFFFFFFFFFFFFFFFFF02);
    run_exp("u64_ovf", 4, 0, 1, 64'd0, 10, 3, 11);
    place(4, 10, 80'h8080808080808080807F);
    run_exp("s64_min", 4, 1, 1, 64'h8000000000000000, 10, 0, 11);
    ub = 20;
    run_exp("mem_err", 10, 0, 0, 64'd0, 0, 1, 2);
    ub = 64;

    // Response held in DONE while a competing request is presented.
    place(2, 1, 80'h05);
    issue(2, 0, 0, v, l, e, lat);
    chk("hold.latency", 64'(lat), 64'd2);
    req_addr = AW'(7); req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("hold.rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold.rsp_value", rsp_value, 64'd5);
      chk("hold.rsp_len", 64'(rsp_len), 64'd1);
      chk("hold.rsp_error", 64'(rsp_error), 64'd0);
      chk("hold.req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    handshake("hold");
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("hold.ignored_req", 64'(rsp_valid), 64'd0);

    // Async reset while decoding a 5-byte operand.
    place(0, 5, 80'h8080808000);
    req_addr = '0; req_signed = 1'b0; req_wide = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid.req_ready", 64'(req_ready), 64'd1);
    chk("rst_mid.mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid.idle", 64'(req_ready), 64'd1);

    // Randomized encodings against the reference model.
    for (int t = 0; t < 40; t++) begin
      int a, lim, n;
      bit s, w;
      logic [7:0] b;
      for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
      a = $urandom_range(0, 31);
      s = 1'($urandom); w = 1'($urandom);
      lim = w ? 10 : 5;
      n = ($urandom_range(0, 2) == 0) ? lim : $urandom_range(1, lim);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        rom[a+i] = (i == n-1) ? (b & 8'h7F) : (b | 8'h80);
      end
      if ($urandom_range(0, 7) == 0)
        for (int i = 0; i < lim; i++) rom[a+i] = rom[a+i] | 8'h80;
      ub = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 46) : 64;
      model(a, s, w, ev, el, ee, elat);
      hv = ev;
      run_exp($sformatf("rand%0d", t), a, s, w, hv, el, ee, elat);
    end
    ub = 64;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
